ecpri_resp_sched: RTL and testbench



---
 rtl/ecpri_resp_sched.sv | 127 ++++++++++++
 tb/tb_ecpri_resp_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecpri_resp_sched.sv
// eCPRI response scheduler.
// Queues write/read response requests from the RX parser in a small FIFO
// and launches them one at a time to the TX builder. The builder is watched
// by a watchdog while each response is in flight.
module ecpri_resp_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 4,    // power of 2, at least 2
  parameter int TIMEOUT     = 255   // 1..255 cycles waiting for tx_done
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         send_write_resp,
  input  logic                         send_read_resp,
  input  logic [DATA_WIDTH-1:0]        resp_payload_len,
  output logic                         tx_start,
  output logic                         tx_type,
  output logic [DATA_WIDTH-1:0]        tx_len,
  input  logic                         tx_done,
  output logic [$clog2(QUEUE_DEPTH):0] q_level,
  output logic                         busy,
  output logic                         overflow,
  output logic                         timeout_err
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 1;  // entry = {type, len}

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [QUEUE_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_slot;
  logic [7:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] len_q;
  logic            type_q;
  logic            pop, push_wr, push_rd, drop, timeout_hit;
  logic [LW-1:0]   free_slots;
  logic [EW-1:0]   head;

  // The pop in LAUNCH frees its slot before this cycle's pushes are judged,
  // so a full FIFO still takes one request during a launch.
  assign pop        = (state == LAUNCH);
  assign free_slots = LW'(QUEUE_DEPTH) - q_level + LW'(pop);
  assign push_wr    = send_write_resp && (free_slots != '0);
  // Write goes first; the read only gets in if a second slot remains.
  assign push_rd    = send_read_resp && (free_slots > LW'(push_wr));
  assign drop       = (send_write_resp && !push_wr) || (send_read_resp && !push_rd);
  assign rd_slot    = wr_ptr + AW'(push_wr);
  assign head       = mem[rd_ptr];

  // A tx_done in the final watchdog cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT_DONE) && !tx_done &&
                       (wait_cnt == 8'(TIMEOUT - 1));

  assign tx_start = (state == LAUNCH);
  assign tx_type  = tx_start ? head[DATA_WIDTH]       : type_q;
  assign tx_len   = tx_start ? head[DATA_WIDTH-1:0]   : len_q;
  assign busy     = (state != IDLE) || (q_level != '0);

  // FIFO storage; contents need no reset since level/pointers gate them.
  always_ff @(posedge clk) begin
    if (push_wr) mem[wr_ptr]  <= {1'b0, resp_payload_len};
    if (push_rd) mem[rd_slot] <= {1'b1, resp_payload_len};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push_wr) + AW'(push_rd);
      rd_ptr  <= rd_ptr + AW'(pop);
      q_level <= q_level + LW'(push_wr) + LW'(push_rd) - LW'(pop);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (q_level != '0) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done || timeout_hit) state_nxt = GAP;
      GAP:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Watchdog counter: cleared on launch, counts every WAIT_DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_cnt <= '0;
    else if (state == LAUNCH)    wait_cnt <= '0;
    else if (state == WAIT_DONE) wait_cnt <= wait_cnt + 8'd1;
  end

  // Hold the last launched type/len so the builder sees stable values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q <= 1'b0;
      len_q  <= '0;
    end else if (pop) begin
      type_q <= head[DATA_WIDTH];
      len_q  <= head[DATA_WIDTH-1:0];
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop)        overflow    <= 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ecpri_resp_sched.sv
// Bench for ecpri_resp_sched: directed scenarios plus a randomized run
// checked against a queue/time-based reference model.
module tb_ecpri_resp_sched;
  localparam int DW = 8, DEPTH = 4, TMO = 10;

  logic clk = 1'b0, reset = 1'b1;
  logic wr = 1'b0, rd = 1'b0, done = 1'b0;
  logic [DW-1:0] len = '0;
  logic tx_start, tx_type, busy, overflow, timeout_err;
  logic [DW-1:0] tx_len;
  logic [2:0] q_level;
  int n_tests = 0, n_fail = 0;

  ecpri_resp_sched #(.DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .send_write_resp(wr), .send_read_resp(rd),
    .resp_payload_len(len), .tx_start(tx_start), .tx_type(tx_type),
    .tx_len(tx_len), .tx_done(done), .q_level(q_level), .busy(busy),
    .overflow(overflow), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic drive(input logic w, input logic r, input logic [DW-1:0] l, input logic d);
    wr = w; rd = r; len = l; done = d;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0); reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick();
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
    n_tests++; if (tx_type !== 1'b0) begin n_fail++; $display("FAIL rst_tx_type: got %b expected 0", tx_type); end
    n_tests++; if (tx_len !== 8'h00) begin n_fail++; $display("FAIL rst_tx_len: got %h expected 00", tx_len); end
    n_tests++; if (q_level !== 3'd0) begin n_fail++; $display("FAIL rst_q_level: got %0d expected 0", q_level); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    reset = 1'b0; tick();
  endtask

  task automatic test_single_read();
    do_reset();
    drive(0, 1, 8'h20, 0); tick(); drive(0, 0, 0, 0);              // n+1
    n_tests++; if (q_level !== 3'd1) begin n_fail++; $display("FAIL single_qlvl: got %0d expected 1", q_level); end
    tick();                                                        // n+2 = c
    n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", tx_start); end
    n_tests++; if (tx_type !== 1'b1) begin n_fail++; $display("FAIL single_type: got %b expected 1", tx_type); end
    n_tests++; if (tx_len !== 8'h20) begin n_fail++; $display("FAIL single_len: got %h expected 20", tx_len); end
    tick();                                                        // c+1
    n_tests++; if (q_level !== 3'd0) begin n_fail++; $display("FAIL single_qlvl0: got %0d expected 0", q_level); end
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0", tx_start); end
    tick(); tick(); drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);  // done at c+3
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %b expected 1", busy); end
    n_tests++; if (tx_len !== 8'h20) begin n_fail++; $display("FAIL single_len_hold: got %h expected 20", tx_len); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 8'h05, 0); tick(); drive(0, 0, 0, 0);
    n_tests++; if (q_level !== 3'd2) begin n_fail++; $display("FAIL b2b_qlvl: got %0d expected 2", q_level); end
    tick();                                                        // c
    n_tests++; if (tx_start !== 1'b1 || tx_type !== 1'b0 || tx_len !== 8'h05) begin
      n_fail++; $display("FAIL b2b_first: got start=%b type=%b len=%h expected 1/0/05", tx_start, tx_type, tx_len); end
    tick(); drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);          // done at c+1
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL b2b_gap2: got %b expected 0", tx_start); end
    tick();
    n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL b2b_gap3: got %b expected 0", tx_start); end
    tick();                                                        // c+4
    n_tests++; if (tx_start !== 1'b1 || tx_type !== 1'b1 || tx_len !== 8'h05) begin
      n_fail++; $display("FAIL b2b_second: got start=%b type=%b len=%h expected 1/1/05", tx_start, tx_type, tx_len); end
    tick(); drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_len [4] = '{8'h03, 8'h04, 8'h05, 8'h77};
    logic          exp_ty  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, 0, 8'(i + 1), 0); tick(); end
    drive(0, 0, 0, 0);                                             // n+5
    n_tests++; if (q_level !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full: got lvl=%0d ovf=%b expected 4/0", q_level, overflow); end
    drive(0, 1, 8'h66, 0); tick(); drive(0, 0, 0, 0);              // n+6
    n_tests++; if (q_level !== 3'd4 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drop: got lvl=%0d ovf=%b expected 4/1", q_level, overflow); end
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0); tick(); tick();  // n+9 launch
    n_tests++; if (tx_start !== 1'b1 || tx_len !== 8'h02) begin
      n_fail++; $display("FAIL ovf_launch2: got start=%b len=%h expected 1/02", tx_start, tx_len); end
    drive(0, 1, 8'h77, 0); tick(); drive(0, 0, 0, 0);              // pushed during launch
    n_tests++; if (q_level !== 3'd4) begin n_fail++; $display("FAIL ovf_accept_on_pop: got %0d expected 4", q_level); end
    tick(); drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      int waited = 0;
      while (tx_start !== 1'b1 && waited < 20) begin tick(); waited++; end
      n_tests++; if (tx_start !== 1'b1 || tx_len !== exp_len[k] || tx_type !== exp_ty[k]) begin
        n_fail++; $display("FAIL ovf_drain%0d: got start=%b type=%b len=%h expected 1/%b/%h", k, tx_start, tx_type, tx_len, exp_ty[k], exp_len[k]); end
      tick(); drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    end
    tick();
    n_tests++; if (busy !== 1'b0 || q_level !== 3'd0) begin
      n_fail++; $display("FAIL ovf_empty: got busy=%b lvl=%0d expected 0/0", busy, q_level); end
  endtask

  task automatic test_done_last_cycle();
    do_reset();
    drive(1, 0, 8'h11, 0); tick(); drive(0, 0, 0, 0); tick();      // c
    n_tests++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL late_start: got %b expected 1", tx_start); end
    for (int i = 0; i < TMO; i++) tick();                          // c+TMO
    drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0);
    n_tests++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL late_done_wins: got to=%b busy=%b expected 0/1", timeout_err, busy); end
    tick();
    n_tests++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL late_idle: got to=%b busy=%b expected 0/0", timeout_err, busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 0, 8'h21, 0); tick(); drive(0, 1, 8'h22, 0); tick(); drive(0, 0, 0, 0); // c
    n_tests++; if (tx_start !== 1'b1 || tx_len !== 8'h21) begin
      n_fail++; $display("FAIL to_start: got start=%b len=%h expected 1/21", tx_start, tx_len); end
    for (int i = 0; i < TMO; i++) tick();                          // c+TMO
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", timeout_err); end
    tick();                                                        // c+TMO+1
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
    tick(); tick();                                                // c+TMO+3
    n_tests++; if (tx_start !== 1'b1 || tx_type !== 1'b1 || tx_len !== 8'h22) begin
      n_fail++; $display("FAIL to_next: got start=%b type=%b len=%h expected 1/1/22", tx_start, tx_type, tx_len); end
    tick(); drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0); tick();
    n_tests++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_after: got busy=%b to=%b expected 0/1", busy, timeout_err); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 8'(8'h31 + i), 0); tick(); end
    drive(0, 0, 0, 0); tick();                                     // in WAIT_DONE, 3 queued
    n_tests++; if (q_level !== 3'd3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got lvl=%0d busy=%b expected 3/1", q_level, busy); end
    #2 reset = 1'b1; #1;
    n_tests++; if ({tx_start, tx_type, tx_len, q_level, busy, overflow, timeout_err} !== '0) begin
      n_fail++; $display("FAIL rmid_outputs: got start=%b type=%b len=%h lvl=%0d busy=%b ovf=%b to=%b expected all 0",
                         tx_start, tx_type, tx_len, q_level, busy, overflow, timeout_err); end
    tick(); reset = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); if (tx_start === 1'b1) seen = 1; end
    n_tests++; if (seen) begin n_fail++; $display("FAIL rmid_quiet: got start seen=1 expected 0"); end
    drive(0, 1, 8'h40, 0); tick(); drive(0, 0, 0, 0); tick();
    n_tests++; if (tx_start !== 1'b1 || tx_len !== 8'h40) begin
      n_fail++; $display("FAIL rmid_new: got start=%b len=%h expected 1/40", tx_start, tx_len); end
    tick(); drive(0, 0, 0, 1); tick(); drive(0, 0, 0, 0); tick();
  endtask

  // Reference model: a queue of {type,len}, the launch cycle of the response
  // in flight, and the first cycle the scheduler is idle again.
  task automatic test_random();
    for (int round = 0; round < 2; round++) begin
      logic [DW:0] mq[$];
      bit m_launch = 0, m_wait = 0, m_ovf = 0, m_to = 0, m_ty = 0;
      logic [DW-1:0] m_ln = '0;
      int m_start = 0, m_idle_from = 0, rate = (round == 0) ? 2 : 5, bad = 0;
      do_reset();
      for (int t = 0; t < 300; t++) begin
        bit idle, w, r, d;
        int sz0, space;
        logic [DW-1:0] l;
        logic [DW:0] hd;
        logic e_ty;
        logic [DW-1:0] e_ln;
        idle = !m_launch && !m_wait && (t >= m_idle_from);
        sz0  = mq.size();
        hd   = m_launch ? mq[0] : {m_ty, m_ln};
        e_ty = hd[DW];
        e_ln = hd[DW-1:0];
        n_tests++;
        if (tx_start !== m_launch || tx_type !== e_ty || tx_len !== e_ln || q_level !== 3'(sz0) ||
            busy !== (!idle || sz0 > 0) || overflow !== m_ovf || timeout_err !== m_to) begin
          n_fail++; bad++;
          if (bad <= 5)
            $display("FAIL rand r%0d t%0d: got start=%b type=%b len=%h lvl=%0d busy=%b ovf=%b to=%b expected %b/%b/%h/%0d/%b/%b/%b",
                     round, t, tx_start, tx_type, tx_len, q_level, busy, overflow, timeout_err,
                     m_launch, e_ty, e_ln, sz0, (!idle || sz0 > 0), m_ovf, m_to);
        end
        w = ($urandom_range(rate - 1) == 0);
        r = ($urandom_range(rate - 1) == 0);
        d = ($urandom_range(3) == 0);
        l = 8'($urandom);
        drive(w, r, l, d);
        if (m_launch) begin
          {m_ty, m_ln} = mq.pop_front(); m_wait = 1; m_start = t;
        end else if (m_wait) begin
          if (d) begin m_wait = 0; m_idle_from = t + 2; end
          else if (t - m_start == TMO) begin m_to = 1; m_wait = 0; m_idle_from = t + 2; end
        end
        space = DEPTH - mq.size();
        if (w) begin if (space > 0) begin mq.push_back({1'b0, l}); space--; end else m_ovf = 1; end
        if (r) begin if (space > 0) mq.push_back({1'b1, l}); else m_ovf = 1; end
        m_launch = idle && (sz0 > 0);
        tick();
      end
      drive(0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_overflow();
    test_done_last_cycle();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
